// File: rtl/dsd_pkg.sv
// Shared constants for the scan decoder: FSM state encoding and mode values.
package dsd_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIRECT     = 2'd1,
    SCAN_ON    = 2'd2,
    SCAN_BLANK = 2'd3
  } dsd_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : dsd_pkg

// File: rtl/dec_low_comb.sv
// Combinational N-to-2^N active-low decoder with enable and an active-channel limit.
module dec_low_comb #(
  parameter int unsigned N        = 4,
  parameter int unsigned CHANNELS = 16
) (
  input  logic              en,
  input  logic [N-1:0]      a,
  output logic [(1<<N)-1:0] y_c,
  output logic              hit_c
);

  // Drive the single addressed bit low when enabled and within the active range.
  always_comb begin
    y_c   = '1;
    hit_c = 1'b0;
    if (en && (32'(a) < CHANNELS)) begin
      y_c[a] = 1'b0;
      hit_c  = 1'b1;
    end
  end

endmodule : dec_low_comb

// File: rtl/scan_decoder_low.sv
// Registered active-low decoder with direct addressing and an autonomous channel scanner.
module scan_decoder_low
  import dsd_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned DWELL_W  = 8,
  parameter int unsigned BLANK    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       w,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(1<<N)-1:0]  y,
  output logic [N-1:0]       cur,
  output logic               sel_valid,
  output logic               wrap
);

  localparam int unsigned NY = 1 << N;

  dsd_state_t         state_q;
  dsd_state_t         state_d;
  logic [DWELL_W-1:0] presc_q;
  logic [DWELL_W-1:0] presc_d;
  logic [N-1:0]       cur_d;
  logic               wrap_d;
  logic               dec_en;
  logic [N-1:0]       dec_addr;
  logic [NY-1:0]      y_d;
  logic               sel_d;

  logic               adv_c;
  logic               last_c;
  logic [N-1:0]       next_ch_c;
  logic [N-1:0]       start_ch_c;

  // Dwell expiry, end-of-sequence detection, successor and clamped start channel.
  always_comb begin
    adv_c      = (presc_q == dwell);
    last_c     = (cur == N'(CHANNELS - 1));
    next_ch_c  = last_c ? '0 : cur + N'(1);
    start_ch_c = (32'(w) < CHANNELS) ? w : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable first, then mode, then the scan sequencing.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DIRECT: state_d = (mode == MODE_SCAN) ? SCAN_ON : DIRECT;
        SCAN_ON: begin
          if (mode == MODE_DIRECT) begin
            state_d = DIRECT;
          end else if (adv_c && (BLANK != 0)) begin
            state_d = SCAN_BLANK;
          end else begin
            state_d = SCAN_ON;
          end
        end
        SCAN_BLANK: state_d = (mode == MODE_DIRECT) ? DIRECT : SCAN_ON;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Output/datapath logic: next channel, prescaler, wrap pulse and decoder request.
  always_comb begin
    cur_d    = cur;
    presc_d  = presc_q;
    wrap_d   = 1'b0;
    dec_en   = 1'b0;
    dec_addr = cur;
    unique case (state_d)
      DIRECT: begin
        cur_d    = w;
        dec_en   = 1'b1;
        dec_addr = w;
      end
      SCAN_ON: begin
        if ((state_q == IDLE) || (state_q == DIRECT)) begin
          cur_d   = start_ch_c;
          presc_d = '0;
        end else if (state_q == SCAN_BLANK) begin
          presc_d = '0;
        end else if (adv_c) begin
          cur_d   = next_ch_c;
          presc_d = '0;
          wrap_d  = last_c;
        end else begin
          presc_d = presc_q + DWELL_W'(1);
        end
        dec_en   = 1'b1;
        dec_addr = cur_d;
      end
      SCAN_BLANK: begin
        cur_d   = next_ch_c;
        presc_d = '0;
        wrap_d  = last_c;
      end
      default: begin
        cur_d = cur;
      end
    endcase
  end

  dec_low_comb #(
    .N        (N),
    .CHANNELS (CHANNELS)
  ) u_dec (
    .en    (dec_en),
    .a     (dec_addr),
    .y_c   (y_d),
    .hit_c (sel_d)
  );

  // Output and prescaler registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '1;
      cur       <= '0;
      sel_valid <= 1'b0;
      wrap      <= 1'b0;
      presc_q   <= '0;
    end else begin
      y         <= y_d;
      cur       <= cur_d;
      sel_valid <= sel_d;
      wrap      <= wrap_d;
      presc_q   <= presc_d;
    end
  end

endmodule : scan_decoder_low

// File: tb/tb_scan_decoder_low.sv
// Bench for scan_decoder_low: three configurations on shared stimulus, checked against a countdown model.
module tb_scan_decoder_low;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [3:0] w;
  logic [7:0] dwell;

  logic [15:0] yo  [NI];
  logic [3:0]  co  [NI];
  logic        svo [NI];
  logic        wro [NI];

  int chn [NI] = '{16, 10, 16};
  int blk [NI] = '{1, 1, 0};

  // Model: 0 = off, 1 = direct, 2 = selecting, 3 = gap cycle
  int kind [NI];
  int ch   [NI];
  int left [NI];
  int mwr  [NI];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  scan_decoder_low #(.N(4), .CHANNELS(16), .DWELL_W(8), .BLANK(1)) d0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w), .dwell(dwell),
    .y(yo[0]), .cur(co[0]), .sel_valid(svo[0]), .wrap(wro[0]));
  scan_decoder_low #(.N(4), .CHANNELS(10), .DWELL_W(8), .BLANK(1)) d1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w), .dwell(dwell),
    .y(yo[1]), .cur(co[1]), .sel_valid(svo[1]), .wrap(wro[1]));
  scan_decoder_low #(.N(4), .CHANNELS(16), .DWELL_W(8), .BLANK(0)) d2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w), .dwell(dwell),
    .y(yo[2]), .cur(co[2]), .sel_valid(svo[2]), .wrap(wro[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step(input int i);
    mwr[i] = 0;
    if (rst) begin
      kind[i] = 0; ch[i] = 0; left[i] = 0;
    end else if (!en) begin
      kind[i] = 0;
    end else if (!mode) begin
      kind[i] = 1; ch[i] = int'(w);
    end else if (kind[i] == 0 || kind[i] == 1) begin
      kind[i] = 2;
      ch[i]   = (int'(w) < chn[i]) ? int'(w) : 0;
      left[i] = int'(dwell);
    end else if (kind[i] == 3) begin
      kind[i] = 2;
      left[i] = int'(dwell);
    end else if (left[i] == 0) begin
      mwr[i] = (ch[i] == chn[i] - 1) ? 1 : 0;
      ch[i]  = (ch[i] + 1) % chn[i];
      if (blk[i] != 0) begin
        kind[i] = 3;
      end else begin
        left[i] = int'(dwell);
      end
    end else begin
      left[i]--;
    end
  endtask

  task automatic compare(input int i);
    logic        sel;
    logic [15:0] ey;
    sel = (kind[i] == 2) || (kind[i] == 1 && ch[i] < chn[i]);
    ey  = sel ? ~(16'(1) << ch[i]) : 16'hFFFF;
    chk($sformatf("d%0d.y", i),         32'(yo[i]),  32'(ey));
    chk($sformatf("d%0d.cur", i),       32'(co[i]),  32'(ch[i]));
    chk($sformatf("d%0d.sel_valid", i), 32'(svo[i]), 32'(sel));
    chk($sformatf("d%0d.wrap", i),      32'(wro[i]), 32'(mwr[i]));
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    for (int i = 0; i < NI; i++) compare(i);
  endtask

  logic [15:0] pat3 [9] = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFF,
                            16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFF, 16'hFFFB};

  initial begin
    for (int i = 0; i < NI; i++) begin
      kind[i] = 0; ch[i] = 0; left[i] = 0; mwr[i] = 0;
    end
    rst = 1'b1; en = 1'b0; mode = 1'b0; w = 4'd0; dwell = 8'd0;

    // Reset, then direct decode of w=5
    cycle();
    cycle();
    chk("reset.y", 32'(yo[0]), 32'h0000_FFFF);
    chk("reset.sv", 32'(svo[0]), 32'd0);
    rst = 1'b0; en = 1'b1; mode = 1'b0; w = 4'd5;
    cycle();
    chk("direct5.y", 32'(yo[0]), 32'h0000_FFDF);
    chk("direct5.cur", 32'(co[0]), 32'd5);
    chk("direct5.sv", 32'(svo[0]), 32'd1);

    // Out-of-range address on the 10-channel instance
    w = 4'd12;
    cycle();
    chk("oor12.y", 32'(yo[1]), 32'h0000_FFFF);
    chk("oor12.sv", 32'(svo[1]), 32'd0);
    w = 4'd9;
    cycle();
    chk("direct9.y", 32'(yo[1]), 32'h0000_FDFF);

    // Scan from 0 with dwell=2 and blanking
    en = 1'b0; dwell = 8'd2;
    cycle();
    en = 1'b1; mode = 1'b1; w = 4'd0;
    cycle();
    chk("scan3.y0", 32'(yo[0]), 32'(pat3[0]));
    for (int k = 1; k < 9; k++) begin
      cycle();
      chk($sformatf("scan3.y%0d", k), 32'(yo[0]), 32'(pat3[k]));
    end
    chk("scan3.cur", 32'(co[0]), 32'd2);

    // Wrap on the unblanked instance, dwell=0, start at 14
    en = 1'b0; dwell = 8'd0;
    cycle();
    en = 1'b1; mode = 1'b1; w = 4'd14;
    cycle();
    chk("wrap.y14", 32'(yo[2]), 32'h0000_BFFF);
    chk("wrap.w14", 32'(wro[2]), 32'd0);
    cycle();
    chk("wrap.y15", 32'(yo[2]), 32'h0000_7FFF);
    chk("wrap.w15", 32'(wro[2]), 32'd0);
    cycle();
    chk("wrap.y0", 32'(yo[2]), 32'h0000_FFFE);
    chk("wrap.cur0", 32'(co[2]), 32'd0);
    chk("wrap.pulse", 32'(wro[2]), 32'd1);
    cycle();
    chk("wrap.after", 32'(wro[2]), 32'd0);

    // Enable drop while on channel 7, then re-entry from 3
    en = 1'b0; dwell = 8'd3;
    cycle();
    en = 1'b1; mode = 1'b1; w = 4'd7;
    cycle();
    chk("endrop.start", 32'(co[0]), 32'd7);
    en = 1'b0;
    cycle();
    chk("endrop.y", 32'(yo[0]), 32'h0000_FFFF);
    chk("endrop.cur", 32'(co[0]), 32'd7);
    en = 1'b1; w = 4'd3;
    cycle();
    chk("reen.cur", 32'(co[0]), 32'd3);
    chk("reen.y", 32'(yo[0]), 32'h0000_FFF7);

    // Run into the blank cycle, then reset during it
    for (int k = 0; k < 4; k++) cycle();
    chk("blank.y", 32'(yo[0]), 32'h0000_FFFF);
    chk("blank.cur", 32'(co[0]), 32'd4);
    rst = 1'b1;
    cycle();
    chk("rstmid.y", 32'(yo[0]), 32'h0000_FFFF);
    chk("rstmid.cur", 32'(co[0]), 32'd0);
    chk("rstmid.sv", 32'(svo[0]), 32'd0);
    chk("rstmid.wrap", 32'(wro[0]), 32'd0);

    // Scan to direct switch
    rst = 1'b0; en = 1'b1; mode = 1'b1; w = 4'd0;
    cycle();
    cycle();
    mode = 1'b0; w = 4'd2;
    cycle();
    chk("m2d.y", 32'(yo[0]), 32'h0000_FFFB);
    chk("m2d.sv", 32'(svo[0]), 32'd1);

    // Randomized traffic; dwell only changes while enable is low
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(49) == 0);
      en  = ($urandom_range(9) != 0);
      if (!en) dwell = 8'($urandom_range(4));
      if ($urandom_range(19) == 0) mode = ~mode;
      w = 4'($urandom_range(15));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_scan_decoder_low

// File: doc/scan_decoder_low.md
Name: scan_decoder_low

Overview:
- Parametrised, registered N-to-2^N decoder with active-low outputs.
- Successor to the 2-to-4/4-to-16 active-low decoder family.
- Adds two modes:
  - direct: registered decode of an input address.
  - scan: autonomous channel sequencer with programmable dwell and optional break-before-make blanking.
- Drives multiplexed-display digit selects and row strobes in lab top-levels.

Parameters:
- N, 4, address width; output width is 2^N.
- CHANNELS, 16, number of active channels (2 to 2^N); outputs at index ≥ CHANNELS are always 1.
- DWELL_W, 8, width of the dwell-count input.
- BLANK, 1, 1 inserts one all-high cycle at every scan advance; 0 disables it.

Ports:
- clk, input, 1, single system clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, global enable; 0 forces y to all-high.
- mode, input, 1, 0 = direct, 1 = scan.
- w, input, N, direct-mode address and scan-mode start channel.
- dwell, input, DWELL_W, scan: the channel is held for dwell+1 select cycles.
- y, output, 2^N, active-low one-cold select.
- cur, output, N, channel currently selected (valid only when sel_valid=1).
- sel_valid, output, 1, 1 when exactly one y bit is low.
- wrap, output, 1, one-cycle pulse when scan advances from CHANNELS-1 to 0.

Behaviour:
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Reset (rst=1 at a clock edge):
  - y = all ones, cur = 0, sel_valid = 0, wrap = 0.
  - Prescaler = 0, state = IDLE.
  - rst takes priority over every other input.
- States: IDLE, DIRECT, SCAN_ON, SCAN_BLANK.
- IDLE:
  - y = all ones, sel_valid = 0.
  - Leaves on en=1: to DIRECT if mode=0, to SCAN_ON if mode=1.
  - On entry to SCAN_ON: cur ← w, prescaler ← 0.
- DIRECT:
  - Each cycle: cur ← w, y ← ~(1<<w), sel_valid ← 1. Latency is 1 cycle from w to y.
  - If w ≥ CHANNELS: y ← all ones, sel_valid ← 0, cur ← w.
  - mode=1 → SCAN_ON with cur ← w, prescaler ← 0.
- SCAN_ON:
  - y = ~(1<<cur), sel_valid = 1.
  - Prescaler increments each cycle. When prescaler == dwell:
    - prescaler ← 0.
    - next = (cur == CHANNELS-1) ? 0 : cur+1.
    - wrap ← 1 for exactly that edge when cur == CHANNELS-1.
    - BLANK=1: go to SCAN_BLANK, with cur ← next.
    - BLANK=0: stay in SCAN_ON, with cur ← next. Outputs change directly with no all-high cycle.
  - dwell=0 advances every cycle (plus the blank cycle when BLANK=1).
  - dwell is sampled live. If dwell is lowered below the current prescaler value, the advance occurs when the prescaler wraps at 2^DWELL_W. The bench must not rely on that case; software changes dwell only while en=0.
- SCAN_BLANK:
  - Lasts exactly one cycle: y = all ones, sel_valid = 0, cur already holds the next channel.
  - Then returns to SCAN_ON.
  - The prescaler holds at 0 during the blank cycle.
- mode=0 in any scan state → DIRECT on the next edge (decode of w).
- en=0 in any state → IDLE on the next edge:
  - y = all ones, sel_valid = 0.
  - cur and prescaler hold their values; re-entry to scan reloads them from w.
- Start channel w ≥ CHANNELS on scan entry: cur ← 0.
- wrap is 0 in every cycle except the advance from CHANNELS-1.
- Exactly-one-low invariant: y has either zero low bits or exactly one low bit, in every cycle.

Decomposition:
- Shared package dsd_pkg holds:
  - state encoding constants: IDLE=2'd0, DIRECT=2'd1, SCAN_ON=2'd2, SCAN_BLANK=2'd3;
  - MODE_DIRECT/MODE_SCAN constants.
- One natural sub-module: dec_low_comb, a parametrised combinational N-to-2^N active-low decoder with enable and a CHANNELS limit. It is instantiated once to produce the next-y value, which is then registered.
- The FSM and prescaler stay in the top module.

Test Plan:
1. Reset, then direct mode: rst=1 for 2 cycles, then en=1, mode=0, w=4'd5. Expect y=16'hFFDF, cur=5, sel_valid=1 one cycle after w is applied, and y=16'hFFFF during reset.
2. Direct out-of-range: CHANNELS=10, w=4'd12. Expect y=16'hFFFF and sel_valid=0. Then w=4'd9 gives y=16'hFDFF.
3. Scan with dwell and blank: BLANK=1, dwell=2, mode=1, w=0. Expect the pattern FFFE ×3, FFFF ×1, FFFD ×3, FFFF, FFFB…, with cur stepping 0,1,2.
4. Wrap: CHANNELS=16, dwell=0, BLANK=0, start w=14. Expect y=BFFF, then 7FFF, then FFFE. wrap=1 coincides only with the edge loading cur=0.
5. Enable drop mid-scan: en=0 while cur=7. Expect y=16'hFFFF on the next cycle, with cur held at 7. Re-enable with w=3: expect scan restarting at cur=3 with y=16'hFFF7.
6. Reset mid-scan, plus mode switch: assert rst during SCAN_BLANK. Expect all outputs at reset values the next cycle. Separately, switching mode 1→0 with w=2 gives y=16'hFFFB one cycle later and no blank cycle.
